// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, 8 data bits LSB first, even parity, 1 stop bit.
// Received bytes are presented on a single-entry AXI-Stream master buffer.
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   boudrate_i            baud select (9600/19200/38400/57600/115200, else 9600)
//   rx_i                  asynchronous serial input, idles high
//   mst_axis_tdata_o      received byte
//   mst_axis_tvalid_o     byte available
//   mst_axis_tlast_o      mirrors tvalid (one-beat packets)
//   mst_axis_tready_i     downstream accepts the byte
//   parity_err_o          1-cycle pulse on parity mismatch
//   frame_err_o           1-cycle pulse when the stop bit is sampled low
//   overrun_o             1-cycle pulse when a good byte is dropped (buffer full)
module uart_rx #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [16:0]           boudrate_i,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] mst_axis_tdata_o,
  output logic                  mst_axis_tvalid_o,
  output logic                  mst_axis_tlast_o,
  input  logic                  mst_axis_tready_i,
  output logic                  parity_err_o,
  output logic                  frame_err_o,
  output logic                  overrun_o
);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop, StWaitIdle
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  perr_q, perr_d;
  logic                  rx_meta_q, rxs_q;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  parity_err_q, parity_err_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic [15:0]           div, half;
  logic                  cnt_clr, byte_done, hs;

  always_comb begin
    unique case (boudrate_i)
      17'd19200:  div = 16'd52;
      17'd38400:  div = 16'd26;
      17'd57600:  div = 16'd17;
      17'd115200: div = 16'd8;
      default:    div = 16'd104;
    endcase
  end

  assign half = div >> 1;

  // Two-flop synchroniser; reset to the idle line level.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rxs_q     <= rx_meta_q;
    end
  end

  // Comparisons use >= so a baud change mid-frame cannot strand the FSM.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    cnt_clr      = 1'b0;
    byte_done    = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rxs_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q >= half) begin
          if (!rxs_q) begin
            state_d   = StData;
            bit_cnt_d = 4'd0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (cnt_q >= div) begin
          cnt_clr   = 1'b1;
          shift_d   = {rxs_q, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(DATA_WIDTH - 1)) state_d = StParity;
        end
      end
      StParity: begin
        if (cnt_q >= div) begin
          perr_d  = rxs_q ^ (^shift_q);
          state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q >= div) begin
          if (!rxs_q) begin
            frame_err_d = 1'b1;
            state_d     = StWaitIdle;
          end else if (perr_q) begin
            parity_err_d = 1'b1;
            state_d      = StIdle;
          end else begin
            byte_done = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      StWaitIdle: begin
        if (rxs_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    cnt_d = (cnt_clr || (state_d != state_q) || (state_q == StIdle)) ? 16'd0 : cnt_q + 16'd1;
  end

  // Single-entry output buffer; a byte landing on a handshake cycle refills it.
  always_comb begin
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    overrun_d = 1'b0;
    hs        = tvalid_q & mst_axis_tready_i;
    if (byte_done) begin
      if (!tvalid_q || hs) begin
        tdata_d  = shift_q;
        tvalid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (hs) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= StIdle;
      cnt_q        <= 16'd0;
      bit_cnt_q    <= 4'd0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign mst_axis_tdata_o  = tdata_q;
  assign mst_axis_tvalid_o = tvalid_q;
  assign mst_axis_tlast_o  = tvalid_q;
  assign parity_err_o      = parity_err_q;
  assign frame_err_o       = frame_err_q;
  assign overrun_o         = overrun_q;

endmodule
